// File: rtl/mhd_pkg.sv
// Shared types and width helpers for the Hamming-distance sequence checker.
package mhd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold a distance of 0..width inclusive.
  function automatic int hd_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit word.
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [HD_W-1:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + HD_W'(d[i]);
    end
  end

endmodule

// File: rtl/mhd_seq_checker.sv
// Compares exact/approximate word streams and reports Hamming-distance violations.
// Optional: define MHD_EARLY_ABORT_EN to end a run at the first violation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting pairs until num_samples have transferred
// ST_DRAIN | all pairs accepted, waiting for the pipeline to empty
// ST_DONE  | results held, start may begin a new run
module mhd_seq_checker
  import mhd_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int MHD   = 5,
  parameter  int CNT_W = 16,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [HD_W-1:0]  max_hd,
  output logic [CNT_W-1:0] first_viol_idx
);

  localparam logic [HD_W:0] MHD_L = (HD_W + 1)'(MHD);

  state_t           state;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_v;
  logic [HD_W-1:0]  s1_hd;
  logic [CNT_W-1:0] s1_idx;
  logic [HD_W-1:0]  hd_comb;
  logic             s1_viol;
  logic             abort_hit;
  logic             xfer;
  logic             last_xfer;

  mhd_popcount #(.WIDTH(WIDTH)) u_popcount (
    .d   (a ^ b),
    .cnt (hd_comb)
  );

  assign s1_viol = s1_v && ({1'b0, s1_hd} > MHD_L);

`ifdef MHD_EARLY_ABORT_EN
  assign abort_hit = s1_viol;
`else
  assign abort_hit = 1'b0;
`endif

  // Ready drops combinationally so no pair enters behind an aborting violation.
  assign in_ready  = (state == ST_RUN) && (acc_cnt < num_q) && !abort_hit;
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (acc_cnt == num_q - CNT_W'(1));
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      num_q          <= '0;
      acc_cnt        <= '0;
      s1_v           <= 1'b0;
      s1_hd          <= '0;
      s1_idx         <= '0;
      done           <= 1'b0;
      fail           <= 1'b0;
      viol_cnt       <= '0;
      max_hd         <= '0;
      first_viol_idx <= '0;
    end else begin
      done <= 1'b0;
      s1_v <= xfer;
      if (xfer) begin
        s1_hd   <= hd_comb;
        s1_idx  <= acc_cnt;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (s1_v) begin
        if (s1_hd > max_hd) max_hd <= s1_hd;
        if (s1_viol) begin
          if (viol_cnt != '1) viol_cnt <= viol_cnt + CNT_W'(1);
          if (viol_cnt == '0) first_viol_idx <= s1_idx;
        end
      end
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_q          <= num_samples;
            acc_cnt        <= '0;
            viol_cnt       <= '0;
            max_hd         <= '0;
            first_viol_idx <= '0;
            fail           <= 1'b0;
            if (num_samples == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort_hit) begin
            state <= ST_DONE;
            done  <= 1'b1;
            fail  <= 1'b1;
            s1_v  <= 1'b0;
          end else if (last_xfer) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort_hit) begin
            state <= ST_DONE;
            done  <= 1'b1;
            fail  <= 1'b1;
            s1_v  <= 1'b0;
          end else if (!s1_v) begin
            // Last pair's result was folded in on the previous edge.
            state <= ST_DONE;
            done  <= 1'b1;
            fail  <= (viol_cnt != '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mhd_seq_checker.sv
// Directed and randomized runs of mhd_seq_checker against a per-run reference model.
module tb_mhd_seq_checker;

  localparam int WIDTH = 16;
  localparam int MHD   = 5;
  localparam int CNT_W = 16;
  localparam int HD_W  = 5;
`ifdef MHD_EARLY_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready, busy, done, fail;
  logic [CNT_W-1:0] viol_cnt, first_viol_idx;
  logic [HD_W-1:0]  max_hd;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mhd_seq_checker #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_samples    (num_samples),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .viol_cnt       (viol_cnt),
    .max_hd         (max_hd),
    .first_viol_idx (first_viol_idx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic make_pair(input int d, output logic [15:0] pa, output logic [15:0] pb);
    logic [15:0] mask;
    mask = '0;
    while ($countones(mask) < d) mask = mask | (16'h0001 << $urandom_range(15, 0));
    pa = 16'($urandom);
    pb = pa ^ mask;
  endtask

  // Drives one complete run from a negedge; returns at a negedge one cycle after done.
  task automatic do_run(input int n, input int hd_q[$], input int vmode, input bit mid_start,
                        input string tag);
    int exp_acc, exp_v, exp_m, first, e, sent, vis_v, vis_m, done_e, exp_de;
    int xc[$];
    int xh[$];
    bit got_done, saw_ready, v, xfer;
    logic [15:0] pa, pb;
    exp_acc = 0; exp_v = 0; exp_m = 0; first = -1;
    e = 0; sent = 0; done_e = -1; got_done = 0; saw_ready = 0;
    for (int i = 0; i < n; i++) begin
      exp_acc++;
      if (hd_q[i] > exp_m) exp_m = hd_q[i];
      if (hd_q[i] > MHD) begin
        if (first < 0) first = i;
        exp_v++;
        if (ABORT) break;
      end
    end
    start = 1'b1; num_samples = CNT_W'(n); in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (!got_done && e < 300) begin
      if (done) begin
        got_done = 1;
        done_e = e;
      end else begin
        vis_v = 0; vis_m = 0;
        foreach (xc[i]) begin
          if (xc[i] <= e - 1) begin
            if (xh[i] > MHD) vis_v++;
            if (xh[i] > vis_m) vis_m = xh[i];
          end
        end
        check({tag, "_viol_live"}, viol_cnt, vis_v);
        check({tag, "_maxhd_live"}, max_hd, vis_m);
        check({tag, "_busy_live"}, busy, 1'b1);
        if (in_ready) saw_ready = 1;
        start = mid_start && (e == 2);
        num_samples = CNT_W'(n + 3);
        v = (sent < n) && (vmode == 0 || (vmode == 1 && e % 2 == 1) ||
                           (vmode == 2 && $urandom_range(1, 0) == 1));
        if (v) make_pair(hd_q[sent], pa, pb);
        else begin pa = 16'($urandom); pb = 16'($urandom); end
        a = pa; b = pb; in_valid = v;
        xfer = v && in_ready;
        @(posedge clk);
        e++;
        if (xfer) begin
          xc.push_back(e);
          xh.push_back(hd_q[sent]);
          sent++;
        end
        @(negedge clk);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check({tag, "_done_seen"}, got_done, 1'b1);
    check({tag, "_xfers"}, sent, exp_acc);
    if (n == 0) exp_de = 0;
    else if (xc.size() > 0) exp_de = xc[xc.size() - 1] + ((ABORT && exp_v > 0) ? 1 : 2);
    else exp_de = -2;
    check({tag, "_done_edge"}, done_e, exp_de);
    check({tag, "_viol_cnt"}, viol_cnt, exp_v);
    check({tag, "_max_hd"}, max_hd, exp_m);
    check({tag, "_fail"}, fail, (exp_v > 0));
    if (exp_v > 0) check({tag, "_first_idx"}, first_viol_idx, first);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_ready_done"}, in_ready, 1'b0);
    if (n == 0) check({tag, "_ready_never"}, saw_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_fail_held"}, fail, (exp_v > 0));
    check({tag, "_viol_held"}, viol_cnt, exp_v);
  endtask

  initial begin
    int q[$];
    int empty_q[$];
    int n, vm;
    logic [15:0] pa, pb;

    #12;
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_viol", viol_cnt, 0);
    check("rst_maxhd", max_hd, 0);
    check("rst_first", first_viol_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    q = '{0, 5, 6, 16};
    do_run(4, q, 0, 1'b0, "basic");
    q = '{0, 0, 0};
    do_run(3, q, 1, 1'b0, "toggle");
    do_run(0, empty_q, 0, 1'b0, "zero");
    q = '{2, 9, 1, 7, 3};
    do_run(5, q, 0, 1'b1, "mid_start");
    q = '{1, 7, 2};
    do_run(3, q, 0, 1'b0, "abort_seq");

    // Reset in the middle of a run, with a violation already visible.
    start = 1'b1; num_samples = CNT_W'(4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("midrst_ready", in_ready, 1'b1);
      make_pair(7, pa, pb);
      a = pa; b = pb; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("midrst_viol_pre", viol_cnt, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready0", in_ready, 1'b0);
    check("midrst_busy0", busy, 1'b0);
    check("midrst_done0", done, 1'b0);
    check("midrst_fail0", fail, 1'b0);
    check("midrst_viol0", viol_cnt, 0);
    check("midrst_maxhd0", max_hd, 0);
    check("midrst_first0", first_viol_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q = '{3, 8, 0, 12};
    do_run(4, q, 0, 1'b0, "post_rst");

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(12, 1);
      vm = $urandom_range(2, 0);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(3, 0) == 0) ? $urandom_range(16, 6) : $urandom_range(5, 0));
      do_run(n, q, vm, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
